// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding word memory with a valid/ready request/response handshake and fixed latency.
// Define DATA_MEMORY_RESPONDER_ERROR_CHECK_EN to reject misaligned or out-of-range addresses.
module data_memory_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY = 2
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic        request_write,
    input  logic [31:0] request_address,
    input  logic [31:0] request_write_data,
    input  logic [3:0]  request_byte_enable,
    output logic        response_valid,
    input  logic        response_ready,
    output logic [31:0] response_read_data,
    output logic        response_error
);
    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;
    localparam bit ZERO_LATENCY = (LATENCY == 0);
    localparam logic [3:0] WAIT_LOAD = ZERO_LATENCY ? 4'd0 : 4'(LATENCY - 1);
    state_t state, state_next;
    logic [3:0] count;
    logic write_q;
    logic [31:0] address_q, write_data_q, read_data_q;
    logic [3:0] byte_enable_q;
    logic [31:0] memory [2**DEPTH_LOG2];
    logic accept, commit, errored;
    logic cur_write;
    logic [31:0] cur_address, cur_write_data;
    logic [3:0] cur_byte_enable;
    logic [DEPTH_LOG2-1:0] word_index;
    // With zero latency the commit happens on the accepting edge, so the live request is used.
    assign cur_write = (state == IDLE) ? request_write : write_q;
    assign cur_address = (state == IDLE) ? request_address : address_q;
    assign cur_write_data = (state == IDLE) ? request_write_data : write_data_q;
    assign cur_byte_enable = (state == IDLE) ? request_byte_enable : byte_enable_q;
    assign word_index = cur_address[DEPTH_LOG2+1:2];
    assign response_read_data = read_data_q;
    always_ff @(posedge system_clock) state <= !reset ? IDLE : state_next;
    always_comb begin
        request_ready = (state == IDLE);
        response_valid = (state == RESPOND);
        accept = request_ready && request_valid;
        commit = (state == BUSY && count == 4'd0) || (accept && ZERO_LATENCY);
        state_next = commit ? RESPOND
                   : accept ? BUSY
                   : (state == RESPOND && response_ready) ? IDLE
                   : state;
    end
    always_ff @(posedge system_clock) begin
        if (accept) begin
            write_q <= request_write;
            address_q <= request_address;
            write_data_q <= request_write_data;
            byte_enable_q <= request_byte_enable;
        end
    end
    always_ff @(posedge system_clock) begin
        if (!reset) begin
            count <= 4'd0;
            read_data_q <= 32'd0;
        end else begin
            if (accept)
                count <= WAIT_LOAD;
            else if (state == BUSY && count != 4'd0)
                count <= count - 4'd1;
            if (commit)
                read_data_q <= (cur_write || errored) ? 32'd0 : memory[word_index];
        end
    end
    // Memory has no reset; a store only lands on the commit edge, so a reset in BUSY drops it.
    always_ff @(posedge system_clock) begin
        if (reset && commit && cur_write && !errored)
            for (int i = 0; i < 4; i++)
                if (cur_byte_enable[i])
                    memory[word_index][8*i +: 8] <= cur_write_data[8*i +: 8];
    end
`ifdef DATA_MEMORY_RESPONDER_ERROR_CHECK_EN
    logic error_q;
    assign errored = (|cur_address[1:0]) || (|cur_address[31:DEPTH_LOG2+2]);
    assign response_error = error_q;
    always_ff @(posedge system_clock) begin
        if (!reset)
            error_q <= 1'b0;
        else if (commit)
            error_q <= errored;
    end
`else
    logic unused_address_bits;
    assign errored = 1'b0;
    assign response_error = 1'b0;
    assign unused_address_bits = ^{cur_address[31:DEPTH_LOG2+2], cur_address[1:0]};
`endif
endmodule
